vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates the 640x480 @ 60 Hz VGA raster timing that the pixel-colour renderer consumes.
- Outputs pixel coordinates `pos_h`/`pos_v`, the `blank` flag, active-low `hsync`/`vsync` and a per-frame tick for the game-state logic.
- Divides the board clock down to the pixel rate with a clock-enable; it does not create a derived clock.
- Sits between the board clock and the renderer; `hsync`/`vsync` drive the VGA connector pins directly.

Parameters:
- CLK_DIV, 2, board clocks per pixel (2 gives 25 MHz from 50 MHz); legal 1..16
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk, input, 1, board clock; single clock domain
- rst, input, 1, asynchronous, active-high reset
- pix_en, output, 1, one-clk pulse every CLK_DIV clks; marks a pixel step
- pos_h, output, 10, current horizontal pixel count, 0..H_TOTAL-1
- pos_v, output, 10, current line count, 0..V_TOTAL-1
- blank, output, 1, high outside the visible area
- hsync, output, 1, active-low horizontal sync, delayed one clk (see Behaviour)
- vsync, output, 1, active-low vertical sync, delayed one clk
- frame_start, output, 1, one-clk pulse when the raster wraps to (0,0)

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Counter compares are at 10-bit width.
- Reset, asynchronous on rst high: div_cnt=0, pos_h=0, pos_v=0, pix_en=0, blank=1, hsync=1, vsync=1, frame_start=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and goes high on the clk after div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pix_en is high every clk after the first post-reset clk.
  - First pix_en pulse: CLK_DIV clks after reset release.
- Counters advance only on the clk where pix_en=1, updated in the same clk:
  - pos_h==H_TOTAL-1 → pos_h=0 and pos_v advances; otherwise pos_h+1.
  - pos_v==V_TOTAL-1 at line wrap → pos_v=0.
  - pos_h, pos_v and blank are all registered together and are always mutually consistent.
- blank = (pos_h >= H_VISIBLE) | (pos_v >= V_VISIBLE), registered alongside the counters.
  - Exception: blank stays 1 from reset until the first pix_en step.
- Sync windows:
  - hsync_raw low for pos_h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751].
  - vsync_raw low for pos_v in [490,491].
- Sync alignment: hsync/vsync are hsync_raw/vsync_raw delayed one further clk. This aligns them with renderer RGB, which is registered one clk after pos_h/pos_v.
- frame_start: one-clk pulse, coincident with the pix_en clk on which the counters wrap from (799,524) to (0,0). Not asserted on reset release.
- Between pix_en pulses all outputs except pix_en and frame_start hold.
- Reset mid-line or mid-sync: all outputs return to reset values immediately; the raster restarts from (0,0) with no partial sync pulse carried over.
- No input handshakes; the block free-runs continuously.

Decomposition:
- Shared package `vga_pkg`:
  - the eight timing constants and derived H_TOTAL/V_TOTAL;
  - sync polarity constant SYNC_ACTIVE=0;
  - coordinate width constant COORD_W=10.
- One sub-module, `vga_axis_counter`: a parameterised wrap counter with parameters VISIBLE/FRONT/SYNC/BACK.
  - Inputs: step. Outputs: count, wrap, in_sync, in_visible.
  - Instantiated twice: horizontal is stepped by pix_en; vertical is stepped by horizontal wrap.

Test Plan:
- Reset then release, CLK_DIV=2 → all outputs at reset values; first pix_en at clk 2; pos_h=1 after it; blank=0 from the first step while pos_h<640.
- Run one line → pos_h steps 0..799 then 0; pos_v increments exactly once; blank rises at pos_h=640; hsync low exactly 96 pixel steps, starting one clk after pos_h reaches 656.
- Run one frame → vsync low for lines 490-491 (2×800 pixel steps), delayed one clk; frame_start pulses once per 420000 pix_en; pix_en period 2 clks.
- Assert rst mid-hsync (pos_h=700, pos_v=100) → hsync=1, pos_h=pos_v=0 and blank=1 immediately; no frame_start on release.
- CLK_DIV=1 → pix_en high continuously after the first clk; frame length 420000 clks; sync positions unchanged.
- Corner wrap (799,524) → next step gives (0,0), frame_start=1 for exactly 1 clk, blank=0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, sync polarity and coordinate width.
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam int COORD_W   = 10;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter for one raster axis with sync-window and visible-area decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE,
  parameter int FRONT   = H_FRONT,
  parameter int SYNC    = H_SYNC,
  parameter int BACK    = H_BACK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               in_sync,
  output logic               in_visible
);
  localparam logic [COORD_W-1:0] LAST = COORD_W'(VISIBLE + FRONT + SYNC + BACK - 1);
  localparam logic [COORD_W-1:0] S_LO = COORD_W'(VISIBLE + FRONT);
  localparam logic [COORD_W-1:0] S_HI = COORD_W'(VISIBLE + FRONT + SYNC);
  localparam logic [COORD_W-1:0] VIS  = COORD_W'(VISIBLE);
  assign wrap       = step && count == LAST;
  assign in_sync    = count >= S_LO && count < S_HI;
  assign in_visible = count < VIS;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (step) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing with a clock-enable pixel divider; counters, pix_en and
// frame_start all change on the same edge, sync outputs lag the counters by one clk.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] pos_h,
  output logic [COORD_W-1:0] pos_v,
  output logic               blank,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic tick, h_wrap, v_wrap, h_sync, v_sync, h_vis, v_vis, live;
  assign tick  = div_cnt == DW'(CLK_DIV - 1);
  // live keeps blank asserted from reset until the first pixel step
  assign blank = ~(live & h_vis & v_vis);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt     <= '0;
      pix_en      <= 1'b0;
      frame_start <= 1'b0;
      live        <= 1'b0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      pix_en      <= tick;
      frame_start <= v_wrap;
      live        <= live | tick;
      hsync       <= h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .clk(clk), .rst(rst), .step(tick), .count(pos_h),
    .wrap(h_wrap), .in_sync(h_sync), .in_visible(h_vis)
  );
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .clk(clk), .rst(rst), .step(h_wrap), .count(pos_v),
    .wrap(v_wrap), .in_sync(v_sync), .in_visible(v_vis)
  );
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: three instances (small raster at CLK_DIV 2 and 1, full 640x480 at CLK_DIV 2)
// compared every clk against a reference computed from elapsed clocks since reset release.
module tb_vga_sync_gen;
  typedef struct { bit pe; int h; int v; bit bl; bit hs; bit vs; bit fs; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int total = 0, bad = 0, k = 0, fs_b = 0;
  logic a_pe, a_bl, a_hs, a_vs, a_fs, b_pe, b_bl, b_hs, b_vs, b_fs, c_pe, c_bl, c_hs, c_vs, c_fs;
  logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
  vga_sync_gen #(.CLK_DIV(2), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
                 .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)) dut_a (
    .clk(clk), .rst(rst), .pix_en(a_pe), .pos_h(a_h), .pos_v(a_v), .blank(a_bl),
    .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs));
  vga_sync_gen #(.CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
                 .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)) dut_b (
    .clk(clk), .rst(rst), .pix_en(b_pe), .pos_h(b_h), .pos_v(b_v), .blank(b_bl),
    .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs));
  vga_sync_gen dut_c (
    .clk(clk), .rst(rst), .pix_en(c_pe), .pos_h(c_h), .pos_v(c_v), .blank(c_bl),
    .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs));

  // Expected outputs after k clk edges since reset release: n pixel steps have happened,
  // and the sync outputs reflect the raster position one edge earlier.
  function automatic exp_t model(input int kk, input int d, input int hv, input int hf,
                                 input int hs, input int hb, input int vv, input int vf,
                                 input int vs, input int vb);
    exp_t e;
    int ht = hv + hf + hs + hb;
    int vt = vv + vf + vs + vb;
    int n  = kk / d;
    int p  = kk > 0 ? (kk - 1) / d : 0;
    int ph = p % ht;
    int pv = (p / ht) % vt;
    e.pe = kk > 0 && kk % d == 0;
    e.h  = n % ht;
    e.v  = (n / ht) % vt;
    e.bl = n == 0 || e.h >= hv || e.v >= vv;
    e.hs = !(kk > 0 && ph >= hv + hf && ph < hv + hf + hs);
    e.vs = !(kk > 0 && pv >= vv + vf && pv < vv + vf + vs);
    e.fs = e.pe && n > 0 && n % (ht * vt) == 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d got=%0d exp=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic chk_inst(input string nm, input exp_t e, input logic pe, input logic [9:0] h,
                          input logic [9:0] v, input logic bl, input logic hs, input logic vs,
                          input logic fs);
    chk({nm, ".pix_en"}, {31'b0, pe}, {31'b0, e.pe});
    chk({nm, ".pos_h"}, {22'b0, h}, e.h);
    chk({nm, ".pos_v"}, {22'b0, v}, e.v);
    chk({nm, ".blank"}, {31'b0, bl}, {31'b0, e.bl});
    chk({nm, ".hsync"}, {31'b0, hs}, {31'b0, e.hs});
    chk({nm, ".vsync"}, {31'b0, vs}, {31'b0, e.vs});
    chk({nm, ".frame_start"}, {31'b0, fs}, {31'b0, e.fs});
  endtask

  task automatic check_all();
    chk_inst("a", model(k, 2, 16, 4, 6, 6, 12, 2, 2, 4), a_pe, a_h, a_v, a_bl, a_hs, a_vs, a_fs);
    chk_inst("b", model(k, 1, 16, 4, 6, 6, 12, 2, 2, 4), b_pe, b_h, b_v, b_bl, b_hs, b_vs, b_fs);
    chk_inst("c", model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33), c_pe, c_h, c_v, c_bl, c_hs,
             c_vs, c_fs);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!rst) k++;
      @(negedge clk);
      if (b_fs === 1'b1) fs_b++;
      check_all();
    end
  endtask

  // Assert reset between edges and check outputs clear without waiting for a clk.
  task automatic hit_reset(input int hold);
    #2 rst = 1'b1;
    #1 k = 0;
    fs_b = 0;
    check_all();
    cyc(hold);
    if (hold == 0) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    int guard;
    cyc(3);
    rst = 1'b0;
    cyc(1800);
    repeat (6) begin
      cyc($urandom_range(1, 1500));
      hit_reset($urandom_range(0, 3));
    end
    guard = 0;
    do begin
      cyc(1);
      guard++;
      e = model(k, 2, 16, 4, 6, 6, 12, 2, 2, 4);
    end while ((e.hs || e.v < 3) && guard < 5000);
    chk("reach_hsync", {31'b0, guard < 5000}, 32'd1);
    hit_reset(2);
    cyc(3000);
    chk("b.frame_count", fs_b, k / 640);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
